// File: rtl/instr_aligner.sv
// Instruction aligner: splits fetch lines into 16-bit parcels and reassembles RISC-V instructions for decode.
// Define ALIGNER_RVC_EN for compressed/straddle support; otherwise odd parcel starts raise dec_fault.
module instr_aligner #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  fetch_rd_en,
  input  logic                  fetch_rd_valid,
  input  logic                  fetch_empty,
  input  logic [DATA_WIDTH-1:0] fetch_instr,
  input  logic                  fetch_is_first,
  input  logic [ADDR_WIDTH-1:0] fetch_base_addr,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [31:0]           dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic                  dec_is_rvc,
  output logic                  dec_fault
);
  localparam int unsigned NP = DATA_WIDTH / 16;
  localparam int unsigned OW = $clog2(NP);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACTIVE, STRAD} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] laddr_q, laddr_d;
  logic [OW-1:0]         ptr_q, ptr_d;
  logic                  sync_wait_q, sync_wait_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                  out_rvc_q, out_rvc_d;
  logic                  out_fault_q, out_fault_d;
`ifdef ALIGNER_RVC_EN
  logic                  pend_valid_q, pend_valid_d;
  logic [15:0]           pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  src_pend;
`endif

  logic                  load, take, src_valid, out_free;
  logic [DATA_WIDTH-1:0] src_line;
  logic [ADDR_WIDTH-1:0] src_addr, src_pc, ex_pc;
  logic [OW-1:0]         src_ptr;
  logic [15:0]           parcel [NP];
  logic                  straddle, last, fault, is_rvc;
  logic [31:0]           ex_instr;
  logic [OW:0]           ptr_sum;

  // The line returning this cycle is decoded directly so the first instruction lands one cycle after rd_valid.
  always_comb begin
    load      = (state_q == WAIT) && fetch_rd_valid && !flush;
    take      = load && (fetch_is_first || !sync_wait_q);
    src_line  = load ? fetch_instr : line_q;
    src_addr  = load ? (fetch_base_addr & ~LINE_MASK) : laddr_q;
    src_ptr   = load ? (fetch_is_first ? fetch_base_addr[OW:1] : '0) : ptr_q;
    src_valid = take || (state_q == ACTIVE) || (state_q == STRAD);
    src_pc    = src_addr + ADDR_WIDTH'({src_ptr, 1'b0});
`ifdef ALIGNER_RVC_EN
    src_pend  = load ? (pend_valid_q && !fetch_is_first) : (state_q == STRAD);
`endif
    for (int unsigned i = 0; i < NP; i++) parcel[i] = src_line[16*i +: 16];
  end

  always_comb begin
    ptr_sum  = {1'b0, src_ptr} + (OW+1)'(2);
    ex_instr = {parcel[src_ptr + OW'(1)], parcel[src_ptr]};
    ex_pc    = src_pc;
    is_rvc   = 1'b0;
    fault    = 1'b0;
    straddle = 1'b0;
`ifdef ALIGNER_RVC_EN
    if (src_pend) begin
      ex_instr = {parcel[0], pend_q};
      ex_pc    = pend_pc_q;
      ptr_sum  = (OW+1)'(1);
    end else if (parcel[src_ptr][1:0] != 2'b11) begin
      ex_instr = {16'h0000, parcel[src_ptr]};
      is_rvc   = 1'b1;
      ptr_sum  = {1'b0, src_ptr} + (OW+1)'(1);
    end else if (src_ptr == OW'(NP - 1)) begin
      straddle = 1'b1;
    end
`else
    if (src_ptr[0]) begin
      ex_instr = '0;
      fault    = 1'b1;
    end
`endif
    last = ptr_sum[OW] || fault;
  end

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    laddr_d     = laddr_q;
    ptr_d       = ptr_q;
    sync_wait_d = sync_wait_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_rvc_d   = out_rvc_q;
    out_fault_d = out_fault_q;
`ifdef ALIGNER_RVC_EN
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
`endif
    fetch_rd_en = 1'b0;
    out_free    = !out_valid_q || dec_ready;
    if (out_free) out_valid_d = 1'b0;

    case (state_q)
      IDLE:    if (!fetch_empty) state_d = REQ;
      REQ:     begin fetch_rd_en = 1'b1; state_d = WAIT; end
      WAIT:    if (fetch_rd_valid && !take) state_d = IDLE;
      default: ;
    endcase

    if (take) begin
      line_d      = fetch_instr;
      laddr_d     = src_addr;
      ptr_d       = src_ptr;
      sync_wait_d = 1'b0;
      state_d     = ACTIVE;
`ifdef ALIGNER_RVC_EN
      pend_valid_d = 1'b0;
      if (src_pend) state_d = STRAD;
`endif
    end

    if (src_valid) begin
      if (straddle) begin
`ifdef ALIGNER_RVC_EN
        pend_valid_d = 1'b1;
        pend_d       = parcel[src_ptr];
        pend_pc_d    = src_pc;
`endif
        state_d = fetch_empty ? IDLE : REQ;
      end else if (out_free) begin
        out_valid_d = 1'b1;
        out_instr_d = ex_instr;
        out_pc_d    = ex_pc;
        out_rvc_d   = is_rvc;
        out_fault_d = fault;
        ptr_d       = ptr_sum[OW-1:0];
        state_d     = last ? (fetch_empty ? IDLE : REQ) : ACTIVE;
        if (fault) sync_wait_d = 1'b1;
      end
    end

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      sync_wait_d = 1'b1;
      fetch_rd_en = 1'b0;
`ifdef ALIGNER_RVC_EN
      pend_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_q      <= '0;
      laddr_q     <= '0;
      ptr_q       <= '0;
      sync_wait_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_rvc_q   <= 1'b0;
      out_fault_q <= 1'b0;
`ifdef ALIGNER_RVC_EN
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      pend_pc_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      laddr_q     <= laddr_d;
      ptr_q       <= ptr_d;
      sync_wait_q <= sync_wait_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_rvc_q   <= out_rvc_d;
      out_fault_q <= out_fault_d;
`ifdef ALIGNER_RVC_EN
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
`endif
    end
  end

  assign dec_valid  = out_valid_q;
  assign dec_instr  = out_instr_q;
  assign dec_pc     = out_pc_q;
  assign dec_is_rvc = out_rvc_q;
  assign dec_fault  = out_fault_q;
endmodule

// File: tb/tb_instr_aligner.sv
// Directed self-checking bench for instr_aligner with a one-read-latency fetch FIFO model.
module tb_instr_aligner;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst_n, flush, fetch_rd_en, fetch_rd_valid, fetch_empty, fetch_is_first;
  logic [DW-1:0] fetch_instr;
  logic [AW-1:0] fetch_base_addr, dec_pc;
  logic          dec_valid, dec_ready, dec_is_rvc, dec_fault;
  logic [31:0]   dec_instr;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          first;
    logic [AW-1:0] base;
  } line_t;
  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic          rvc;
    logic          fault;
    int unsigned   cyc;
  } beat_t;

  line_t       fq[$];
  beat_t       cap[$];
  int unsigned cyc = 0, rdv_cyc = 0, rd_count = 0, total = 0, passed = 0;

  instr_aligner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_rd_en(fetch_rd_en), .fetch_rd_valid(fetch_rd_valid), .fetch_empty(fetch_empty),
    .fetch_instr(fetch_instr), .fetch_is_first(fetch_is_first), .fetch_base_addr(fetch_base_addr),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_is_rvc(dec_is_rvc), .dec_fault(dec_fault)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Fetch FIFO: read data appears exactly one cycle after the cycle fetch_rd_en was high.
  initial begin
    logic  req;
    line_t l;
    fetch_rd_valid = 1'b0; fetch_instr = '0; fetch_is_first = 1'b0;
    fetch_base_addr = '0; fetch_empty = 1'b1;
    forever begin
      @(negedge clk);
      req = fetch_rd_en;
      if (req) rd_count++;
      @(posedge clk); #1;
      fetch_rd_valid = 1'b0;
      if (req && fq.size() > 0) begin
        l = fq.pop_front();
        fetch_instr = l.data; fetch_is_first = l.first; fetch_base_addr = l.base;
        fetch_rd_valid = 1'b1;
        rdv_cyc = cyc;
        fetch_empty = (fq.size() == 0);
      end
    end
  end

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && dec_valid && dec_ready) begin
        b.instr = dec_instr; b.pc = dec_pc; b.rvc = dec_is_rvc; b.fault = dec_fault; b.cyc = cyc;
        cap.push_back(b);
      end
    end
  end

  initial begin #2_000_000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

  task automatic push(input logic [DW-1:0] d, input logic f, input logic [AW-1:0] b);
    line_t l;
    l.data = d; l.first = f; l.base = b;
    fq.push_back(l);
    fetch_empty = 1'b0;
  endtask

  task automatic wait_beats(input int unsigned n);
    for (int i = 0; i < 300; i++) begin
      if (cap.size() >= n) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({dec_valid, fetch_rd_en, dec_is_rvc, dec_fault} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {dec_valid, fetch_rd_en, dec_is_rvc, dec_fault}); else passed++;
    total++; if (dec_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", dec_instr); else passed++;
    total++; if (dec_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", dec_pc); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (fetch_rd_en !== 1'b0 || dec_valid !== 1'b0)
      $display("FAIL idle_empty: got rd_en=%b valid=%b want 0 0", fetch_rd_en, dec_valid); else passed++;
  endtask

  task automatic test_nops;
    beat_t g;
    cap.delete();
    push({4{32'h00000013}}, 1'b1, 32'h100);
    wait_beats(4);
    total++; if (cap.size() != 4) $display("FAIL nops_count: got %0d want 4", cap.size()); else passed++;
    g = '0; if (cap.size() > 0) g = cap[0];
    total++; if (g.cyc != rdv_cyc + 1) $display("FAIL nops_latency: got cycle %0d want %0d", g.cyc, rdv_cyc + 1); else passed++;
    for (int i = 0; i < 4; i++) begin
      g = '0; if (i < cap.size()) g = cap[i];
      total++;
      if (g.instr !== 32'h13 || g.pc !== 32'h100 + 4*i || g.rvc !== 1'b0 || g.fault !== 1'b0)
        $display("FAIL nops_beat%0d: got instr=%h pc=%h rvc=%b flt=%b want instr=00000013 pc=%h rvc=0 flt=0",
                 i, g.instr, g.pc, g.rvc, g.fault, 32'h100 + 4*i);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    beat_t       g;
    logic [31:0] ei [6] = '{32'hA0000083, 32'hB0000103, 32'h11111113, 32'h22222213, 32'h33333313, 32'h44444413};
    logic [31:0] ep [6] = '{32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C};
    cap.delete();
    push({32'hB0000103, 32'hA0000083, 64'h0}, 1'b1, 32'h108);
    push(128'h44444413_33333313_22222213_11111113, 1'b0, 32'h110);
    wait_beats(6);
    total++; if (cap.size() != 6) $display("FAIL b2b_count: got %0d want 6", cap.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      g = '0; if (i < cap.size()) g = cap[i];
      total++;
      if (g.instr !== ei[i] || g.pc !== ep[i] || g.fault !== 1'b0)
        $display("FAIL b2b_beat%0d: got instr=%h pc=%h flt=%b want instr=%h pc=%h flt=0",
                 i, g.instr, g.pc, g.fault, ei[i], ep[i]);
      else passed++;
    end
  endtask

`ifdef ALIGNER_RVC_EN
  task automatic test_rvc;
    beat_t       g;
    logic [31:0] ei [3] = '{32'h00000001, 32'h00000013, 32'h00000013};
    logic [31:0] ep [3] = '{32'h206, 32'h208, 32'h20C};
    logic        er [3] = '{1'b1, 1'b0, 1'b0};
    cap.delete();
    push(128'h0000_0013_0000_0013_0001_0000_0000_0000, 1'b1, 32'h206);
    wait_beats(3);
    total++; if (cap.size() != 3) $display("FAIL rvc_count: got %0d want 3", cap.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      g = '0; if (i < cap.size()) g = cap[i];
      total++;
      if (g.instr !== ei[i] || g.pc !== ep[i] || g.rvc !== er[i] || g.fault !== 1'b0)
        $display("FAIL rvc_beat%0d: got instr=%h pc=%h rvc=%b want instr=%h pc=%h rvc=%b",
                 i, g.instr, g.pc, g.rvc, ei[i], ep[i], er[i]);
      else passed++;
    end
  endtask

  task automatic test_straddle;
    beat_t       g;
    logic [31:0] ei [3] = '{32'h00000001, 32'h12345093, 32'h00000013};
    logic [31:0] ep [3] = '{32'h30C, 32'h30E, 32'h312};
    logic        er [3] = '{1'b1, 1'b0, 1'b0};
    cap.delete();
    push(128'h5093_0001_0000_0000_0000_0000_0000_0000, 1'b1, 32'h30C);
    push(128'h0001_0001_0001_0001_0001_0000_0013_1234, 1'b0, 32'h310);
    wait_beats(8);
    total++; if (cap.size() != 8) $display("FAIL strad_count: got %0d want 8", cap.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      g = '0; if (i < cap.size()) g = cap[i];
      total++;
      if (g.instr !== ei[i] || g.pc !== ep[i] || g.rvc !== er[i])
        $display("FAIL strad_beat%0d: got instr=%h pc=%h rvc=%b want instr=%h pc=%h rvc=%b",
                 i, g.instr, g.pc, g.rvc, ei[i], ep[i], er[i]);
      else passed++;
    end
  endtask
`endif

  task automatic test_stall;
    beat_t       g;
    int unsigned k, rd0;
    logic [31:0] ei [8] = '{32'hD013, 32'hC013, 32'hB013, 32'hA013, 32'h13, 32'h13, 32'h13, 32'h13};
    cap.delete();
    @(posedge clk); #1 dec_ready = 1'b0;
    rd0 = rd_count;
    push(128'h0000A013_0000B013_0000C013_0000D013, 1'b1, 32'h500);
    push({4{32'h00000013}}, 1'b0, 32'h510);
    k = 0;
    while (dec_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    total++; if (k >= 100) $display("FAIL stall_valid_timeout: got no dec_valid within %0d cycles", k); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (dec_valid !== 1'b1 || dec_instr !== 32'h0000D013 || dec_pc !== 32'h500)
        $display("FAIL stall_hold%0d: got valid=%b instr=%h pc=%h want 1 0000d013 00000500", i, dec_valid, dec_instr, dec_pc);
      else passed++;
    end
    total++; if (rd_count - rd0 != 1) $display("FAIL stall_reads: got %0d reads want 1", rd_count - rd0); else passed++;
    @(posedge clk); #1 dec_ready = 1'b1;
    wait_beats(8);
    total++; if (cap.size() != 8) $display("FAIL stall_count: got %0d want 8", cap.size()); else passed++;
    for (int i = 0; i < 8; i++) begin
      g = '0; if (i < cap.size()) g = cap[i];
      total++;
      if (g.instr !== ei[i] || g.pc !== 32'h500 + 4*i)
        $display("FAIL stall_beat%0d: got instr=%h pc=%h want instr=%h pc=%h", i, g.instr, g.pc, ei[i], 32'h500 + 4*i);
      else passed++;
    end
  endtask

  task automatic test_flush;
    beat_t       g;
    int unsigned k;
    cap.delete();
    push({4{32'h00000013}}, 1'b0, 32'h610);
    push(128'h00000413_00000313_00000213_00000113, 1'b1, 32'h400);
    k = 0;
    while (fetch_rd_en !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    total++; if (k >= 100) $display("FAIL flush_rd_timeout: got no fetch_rd_en within %0d cycles", k); else passed++;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    total++; if (dec_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", dec_valid); else passed++;
    wait_beats(4);
    total++; if (cap.size() != 4) $display("FAIL flush_count: got %0d want 4", cap.size()); else passed++;
    g = '0; if (cap.size() > 0) g = cap[0];
    total++; if (g.pc !== 32'h400 || g.instr !== 32'h113)
      $display("FAIL flush_first: got pc=%h instr=%h want pc=00000400 instr=00000113", g.pc, g.instr); else passed++;

    // Flush while an instruction sits stalled in the output register.
    cap.delete();
    @(posedge clk); #1 dec_ready = 1'b0;
    push({4{32'h00000013}}, 1'b1, 32'h700);
    k = 0;
    while (dec_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; dec_ready = 1'b1;
    @(negedge clk);
    total++; if (dec_valid !== 1'b0 || k >= 100)
      $display("FAIL flush_stalled: got valid=%b wait=%0d want valid 0 after a held beat", dec_valid, k); else passed++;
    wait_beats(0);
    total++; if (cap.size() != 0) $display("FAIL flush_discard: got %0d beats want 0", cap.size()); else passed++;
  endtask

`ifndef ALIGNER_RVC_EN
  task automatic test_fault;
    beat_t g;
    cap.delete();
    push({4{32'h00000013}}, 1'b1, 32'h102);
    push({4{32'h77777713}}, 1'b0, 32'h110);
    push(128'h00000D13_00000C13_00000B13_00000A13, 1'b1, 32'h200);
    wait_beats(5);
    total++; if (cap.size() != 5) $display("FAIL fault_count: got %0d want 5", cap.size()); else passed++;
    g = '0; if (cap.size() > 0) g = cap[0];
    total++; if (g.fault !== 1'b1 || g.instr !== 32'h0 || g.pc !== 32'h102 || g.rvc !== 1'b0)
      $display("FAIL fault_beat: got flt=%b instr=%h pc=%h rvc=%b want 1 00000000 00000102 0", g.fault, g.instr, g.pc, g.rvc);
    else passed++;
    g = '0; if (cap.size() > 1) g = cap[1];
    total++; if (g.fault !== 1'b0 || g.instr !== 32'hA13 || g.pc !== 32'h200)
      $display("FAIL fault_resync: got flt=%b instr=%h pc=%h want 0 00000a13 00000200", g.fault, g.instr, g.pc);
    else passed++;
  endtask
`endif

  task automatic test_wrap;
    beat_t       g;
    logic [31:0] ei [5] = '{32'hFEEDF013, 32'h13, 32'h13, 32'h13, 32'h13};
    logic [31:0] ep [5] = '{32'hFFFFFFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    cap.delete();
    push({32'hFEEDF013, 96'h0}, 1'b1, 32'hFFFFFFFC);
    push({4{32'h00000013}}, 1'b0, 32'h0);
    wait_beats(5);
    total++; if (cap.size() != 5) $display("FAIL wrap_count: got %0d want 5", cap.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      g = '0; if (i < cap.size()) g = cap[i];
      total++;
      if (g.instr !== ei[i] || g.pc !== ep[i])
        $display("FAIL wrap_beat%0d: got instr=%h pc=%h want instr=%h pc=%h", i, g.instr, g.pc, ei[i], ep[i]);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; dec_ready = 1'b1;
    test_reset;
    test_nops;
    test_back_to_back;
`ifdef ALIGNER_RVC_EN
    test_rvc;
    test_straddle;
`endif
    test_stall;
    test_flush;
`ifndef ALIGNER_RVC_EN
    test_fault;
`endif
    test_wrap;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_aligner.md
Name: instr_aligner

Overview:
- Sits directly downstream of the instruction fetch FIFO.
- Consumes fetch lines (DATA_WIDTH bits each), each tagged with is_first and base_addr.
- Splits each line into 16-bit parcels and reassembles 16/32-bit RISC-V instructions, including 32-bit instructions that straddle two lines.
- Presents one instruction per cycle, with its PC, to decode over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 32: address/PC width.
- DATA_WIDTH, 128: fetch line width; must be a power of two and >= 32. NP = DATA_WIDTH/16 parcels per line; OW = log2(NP) offset bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  discard all buffered state; resync on the next is_first line.
- fetch_rd_en  out  1  one-cycle read pulse to the fetch FIFO.
- fetch_rd_valid  in  1  read data valid; arrives exactly 1 cycle after fetch_rd_en.
- fetch_empty  in  1  fetch FIFO empty.
- fetch_instr  in  DATA_WIDTH  line data; parcel k = bits [16k+15:16k].
- fetch_is_first  in  1  line starts a new stream at base_addr (unpacked param field).
- fetch_base_addr  in  ADDR_WIDTH  start address if is_first, else the line-aligned address.
- dec_valid  out  1  instruction available.
- dec_ready  in  1  decode accepts.
- dec_instr  out  32  instruction; compressed instructions zero-extended to 32 bits.
- dec_pc  out  ADDR_WIDTH  PC of dec_instr.
- dec_is_rvc  out  1  dec_instr is 16-bit.
- dec_fault  out  1  misalignment fault (see Optional Feature); always 0 when the feature is compiled in.

Behaviour:
- Reset: all outputs 0; state IDLE; line buffer invalid; pending half cleared; sync_wait = 1.
- Line buffer: line data, line address (base_addr with low log2(DATA_WIDTH/8) bits cleared), parcel offset ptr (OW bits).
- Offset on load: is_first line sets ptr = base_addr[OW:1]; otherwise ptr = 0.
- sync_wait:
  - Set by reset and by flush.
  - While set, lines with is_first = 0 are dropped (the read is still consumed).
  - Cleared when an is_first = 1 line loads.
- States:
  - IDLE: no line held. Enter REQ when fetch_empty = 0.
  - REQ: fetch_rd_en = 1 for exactly one cycle, then WAIT.
  - WAIT: on fetch_rd_valid, load the line and go to ACTIVE, or drop it per sync_wait and go to IDLE.
  - ACTIVE: extract instructions.
  - STRAD: holds the low half of a straddling 32-bit instruction; the next read is in progress.
- At most one read outstanding.
- Parcel at ptr with bits[1:0] != 2'b11: 16-bit instruction; PC = line address + 2*ptr; ptr += 1.
- Otherwise: 32-bit instruction; ptr += 2.
- Straddle: 32-bit instruction with ptr = NP-1.
  - Store the low parcel and its PC in the pending register, then issue a read (enter STRAD via REQ/WAIT).
  - On the next line: if is_first = 0, output {parcel0, pending} with the pending PC and set ptr = 1.
  - If is_first = 1: discard pending and load normally.
- Line exhausted (ptr wraps to 0, or ptr + 2 = NP): return to IDLE/REQ in the same cycle the last instruction enters the output register.
  - No prefetch; ACTIVE-to-ACTIVE bubble is 2 cycles.
- Output register: loaded when !dec_valid or (dec_valid & dec_ready).
  - Output fields are held stable while dec_valid & !dec_ready; the buffer stalls.
  - Latency: fetch_rd_valid in cycle N gives dec_valid in cycle N+1 for the first instruction of the line.
- Flush: takes priority over everything in the same cycle.
  - Next cycle: dec_valid = 0, state IDLE, buffer and pending invalid, sync_wait = 1.
  - A read returning in the flush cycle or after it is governed by sync_wait.
- PC arithmetic is modulo 2^ADDR_WIDTH; a line address of all-ones wraps to 0.

Optional Feature:
- Macro ALIGNER_RVC_EN.
- Defined: behaviour as above.
- Undefined:
  - Every parcel pair is treated as a 32-bit instruction; dec_is_rvc = 0.
  - Odd ptr at load (base_addr[1] = 1) emits one instruction with dec_fault = 1, dec_instr = 0 and PC = base_addr, then enters sync_wait.
  - Straddling cannot occur; the pending register is omitted.

Test Plan:
- Reset, then one line (is_first = 1, base 0x100) of four 32-bit NOPs 0x00000013 -> four dec_valid beats, PCs 0x100/0x104/0x108/0x10C, dec_is_rvc = 0.
- is_first line, base 0x206, containing C.NOP 0x0001 at parcel 3, then 32-bit instructions -> first output PC 0x206, dec_instr 0x00000001, dec_is_rvc = 1; next PC 0x208.
- 32-bit instruction 0x12345093 with low half 0x5093 in parcel 7 of line 0x300 and high half 0x1234 in parcel 0 of line 0x310 -> dec_instr 0x12345093, PC 0x30E; next PC 0x312.
- dec_ready held low for 5 cycles with dec_valid = 1 -> dec_instr and dec_pc unchanged; no further fetch_rd_en beyond one outstanding read.
- Flush asserted in the cycle fetch_rd_valid returns a non-first line, followed by an is_first line at 0x400 -> non-first line dropped; first output PC 0x400.
- ALIGNER_RVC_EN undefined, is_first base 0x102 -> one beat with dec_fault = 1, PC 0x102; no further output until the next is_first line.
